memory_to_dram: RTL and testbench

MEMORY_TO_DRAM -- requirements
Module: memory_to_dram

---
 rtl/memory_to_dram.sv | 158 +++++++++++++++
 tb/tb_memory_to_dram.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_to_dram.sv
// Streams memory words out to a narrow DRAM sink: one memory read per word, then
// the word is serialized MSB-first into DRAM_DATA_BITWIDTH chunks with
// valid/ready handshaking. A one-word pending buffer hides read latency so that
// consecutive words stream without bubbles.
module memory_to_dram #(
  parameter int unsigned MEM_DATA_BITWIDTH  = 163,
  parameter int unsigned DRAM_DATA_BITWIDTH = 8,
  parameter int unsigned ADDR_BITWIDTH      = 10
) (
  input  logic                          clk_i,
  input  logic                          dram_to_mem_rst_i,
  input  logic                          start_i,
  input  logic [ADDR_BITWIDTH-1:0]      base_addr_i,
  input  logic [ADDR_BITWIDTH:0]        num_words_i,
  output logic                          mem_rd_en_o,
  output logic [ADDR_BITWIDTH-1:0]      mem_rd_addr_o,
  input  logic [MEM_DATA_BITWIDTH-1:0]  mem_data_i,
  output logic [DRAM_DATA_BITWIDTH-1:0] dram_data_o,
  output logic                          dram_valid_o,
  input  logic                          dram_ready_i,
  output logic                          dram_last_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int unsigned NUM_CHUNKS = (MEM_DATA_BITWIDTH + DRAM_DATA_BITWIDTH - 1) / DRAM_DATA_BITWIDTH;
  localparam int unsigned SR_W       = NUM_CHUNKS * DRAM_DATA_BITWIDTH;
  localparam int unsigned PAD        = SR_W - MEM_DATA_BITWIDTH;
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);
  localparam int unsigned NW_W       = ADDR_BITWIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state;
  logic [ADDR_BITWIDTH-1:0]       base_q;
  logic [NW_W-1:0]                num_q;
  logic [NW_W-1:0]                issued;
  logic [NW_W-1:0]                returned;
  logic                           rd_pend;
  logic [SR_W-1:0]                sr;
  logic                           sr_valid;
  logic                           sr_last;
  logic [CNT_W-1:0]               chunk_cnt;
  logic [MEM_DATA_BITWIDTH-1:0]   pend_data;
  logic                           pend_full;
  logic                           pend_last;

  logic accept_c, last_chunk_c, word_end_c, ret_last_c, can_issue_c;

  // Word placed MSB-first in the shift register, zero padding at the LSB end.
  function automatic logic [SR_W-1:0] pack(input logic [MEM_DATA_BITWIDTH-1:0] w);
    return SR_W'(w) << PAD;
  endfunction

  assign accept_c     = sr_valid & dram_ready_i;
  assign last_chunk_c = (chunk_cnt == CNT_W'(NUM_CHUNKS - 1));
  assign word_end_c   = accept_c & last_chunk_c;
  assign ret_last_c   = ((returned + NW_W'(1)) == num_q);
  assign can_issue_c  = (state == RUN) && (issued < num_q) && !mem_rd_en_o && !rd_pend && !pend_full;

  assign dram_data_o  = sr[SR_W-1 -: DRAM_DATA_BITWIDTH];
  assign dram_valid_o = sr_valid;
  assign dram_last_o  = sr_valid & sr_last & last_chunk_c;

  // Control FSM, read issue, shift register and pending buffer.
  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      state         <= IDLE;
      base_q        <= '0;
      num_q         <= '0;
      issued        <= '0;
      returned      <= '0;
      rd_pend       <= 1'b0;
      sr            <= '0;
      sr_valid      <= 1'b0;
      sr_last       <= 1'b0;
      chunk_cnt     <= '0;
      pend_data     <= '0;
      pend_full     <= 1'b0;
      pend_last     <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_rd_addr_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      done_o      <= 1'b0;
      mem_rd_en_o <= 1'b0;
      rd_pend     <= mem_rd_en_o;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (num_words_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state         <= RUN;
              busy_o        <= 1'b1;
              base_q        <= base_addr_i;
              num_q         <= num_words_i;
              issued        <= NW_W'(1);
              returned      <= '0;
              mem_rd_en_o   <= 1'b1;
              mem_rd_addr_o <= base_addr_i;
            end
          end
        end
        RUN: begin
          if (can_issue_c) begin
            mem_rd_en_o   <= 1'b1;
            mem_rd_addr_o <= base_q + ADDR_BITWIDTH'(issued);
            issued        <= issued + NW_W'(1);
          end
          if (rd_pend) begin
            returned <= returned + NW_W'(1);
          end
          if (word_end_c) begin
            chunk_cnt <= '0;
            if (pend_full) begin
              sr        <= pack(pend_data);
              sr_last   <= pend_last;
              pend_full <= 1'b0;
            end else if (rd_pend) begin
              sr      <= pack(mem_data_i);
              sr_last <= ret_last_c;
            end else begin
              sr       <= '0;
              sr_valid <= 1'b0;
              sr_last  <= 1'b0;
            end
            if (sr_last) begin
              state  <= IDLE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end else begin
            if (accept_c) begin
              sr        <= sr << DRAM_DATA_BITWIDTH;
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
            if (rd_pend) begin
              if (!sr_valid) begin
                sr        <= pack(mem_data_i);
                sr_valid  <= 1'b1;
                sr_last   <= ret_last_c;
                chunk_cnt <= '0;
              end else begin
                pend_data <= mem_data_i;
                pend_full <= 1'b1;
                pend_last <= ret_last_c;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_to_dram.sv
// Self-checking bench for memory_to_dram: vector table of transfers plus a
// mid-transfer reset sequence; expected chunks come from a scoreboard queue.
module tb_memory_to_dram;
  localparam int unsigned MW = 163;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned NC = 21;
  localparam int unsigned SW = NC * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   num;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [MW-1:0] mem_data;
  logic [DW-1:0] dram_data;
  logic          valid;
  logic          ready;
  logic          last;
  logic          busy;
  logic          done;

  memory_to_dram dut (
    .clk_i(clk), .dram_to_mem_rst_i(rst), .start_i(start), .base_addr_i(base),
    .num_words_i(num), .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr),
    .mem_data_i(mem_data), .dram_data_o(dram_data), .dram_valid_o(valid),
    .dram_ready_i(ready), .dram_last_o(last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned base;
    int unsigned num;
    bit          special;
    bit          rnd;
    bit          poke;
  } vec_t;

  logic [DW:0]   exp_q[$];
  int unsigned   rd_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            done_cnt, done_cyc, last_cyc, chunk_idx, gaps, valid_cycles;
  bit            done_busy;
  bit            special = 1'b0;
  bit            rnd_mode = 1'b0;
  logic [DW-1:0] first_chunk, final_chunk;

  always @(posedge clk) cyc <= cyc + 1;

  function void check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [MW-1:0] word_fn(input logic [AW-1:0] a);
    logic [MW-1:0] w;
    w = '0;
    if (special) begin
      w[MW-1] = 1'b1;
      w[0]    = 1'b1;
      return w;
    end
    for (int i = 0; i < 6; i++)
      w = {w[MW-33:0], 32'(a) * 32'h9E3779B1 + 32'(i) * 32'h7F4A7C15 + 32'h01234567};
    return w;
  endfunction

  task automatic push_expected(input int unsigned b, input int unsigned n);
    logic [SW-1:0] s;
    for (int w = 0; w < int'(n); w++) begin
      s = SW'(word_fn(AW'(b + w))) << (SW - MW);
      for (int k = 0; k < int'(NC); k++) begin
        exp_q.push_back({(w == int'(n) - 1) && (k == int'(NC) - 1), s[SW-1 -: DW]});
        s = s << DW;
      end
    end
  endtask

  // Memory model: data returned one cycle after each read strobe.
  initial begin
    bit            seen;
    logic [AW-1:0] a;
    mem_data = '0;
    forever begin
      @(negedge clk);
      seen = rd_en;
      a    = rd_addr;
      if (seen) rd_q.push_back(int'(a));
      @(posedge clk);
      #1;
      mem_data = seen ? word_fn(a) : '0;
    end
  end

  // Sink readiness: held high, or random when backpressure is exercised.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, gaps, done timing.
  initial begin
    bit            prev_stall = 1'b0;
    logic [DW-1:0] p_data;
    logic          p_last;
    bit            streaming = 1'b0;
    logic [DW:0]   e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall) begin
          check("stall_valid", 64'(valid), 64'(1));
          check("stall_data", 64'(dram_data), 64'(p_data));
          check("stall_last", 64'(last), 64'(p_last));
        end
        if (streaming && !valid) gaps++;
        if (valid) begin
          streaming = 1'b1;
          valid_cycles++;
        end
        if (valid && ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_chunk", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("chunk_data", 64'(dram_data), 64'(e[DW-1:0]));
            check("chunk_last", 64'(last), 64'(e[DW]));
          end
          if (chunk_idx == 0) first_chunk = dram_data;
          final_chunk = dram_data;
          chunk_idx++;
          if (last) begin
            last_cyc  = cyc;
            streaming = 1'b0;
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
      end else begin
        streaming = 1'b0;
      end
      prev_stall = !rst && valid && !ready;
      p_data     = dram_data;
      p_last     = last;
    end
  end

  task automatic run(input vec_t v);
    int acc;
    rd_q.delete();
    gaps = 0; done_cnt = 0; chunk_idx = 0; valid_cycles = 0; last_cyc = -100; done_cyc = -1;
    special  = v.special;
    rnd_mode = v.rnd;
    push_expected(v.base, v.num);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(v.base); num = (AW+1)'(v.num);
    @(posedge clk); #1;
    start = 1'b0;
    acc = cyc;
    @(negedge clk);
    check("first_rd_en", 64'(rd_en), 64'(v.num != 0));
    check("busy_after_start", 64'(busy), 64'(v.num != 0));
    if (v.poke) begin
      repeat (4) @(posedge clk);
      #1; start = 1'b1; base = AW'(300); num = (AW+1)'(5);
      @(posedge clk); #1; start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) begin
      check("done_timeout", 64'(0), 64'(1));
    end else begin
      if (v.num == 0) check("done_cyc_zero", 64'(done_cyc), 64'(acc));
      else check("done_cyc", 64'(done_cyc), 64'(last_cyc + 1));
      check("busy_at_done", 64'(done_busy), 64'(0));
    end
    repeat (3) @(negedge clk);
    rnd_mode = 1'b0;
    check("done_once", 64'(done_cnt), 64'(1));
    check("exp_empty", 64'(exp_q.size()), 64'(0));
    check("num_reads", 64'(rd_q.size()), 64'(v.num));
    for (int i = 0; i < rd_q.size() && i < int'(v.num); i++)
      check("rd_addr", 64'(rd_q[i]), 64'((v.base + i) % 1024));
    if (!v.rnd && v.num != 0) check("stream_gaps", 64'(gaps), 64'(0));
    if (v.num == 0) check("no_valid_zero", 64'(valid_cycles), 64'(0));
    if (v.special) begin
      check("chunk0_const", 64'(first_chunk), 64'(8'h80));
      check("chunk20_const", 64'(final_chunk), 64'(8'h20));
    end
    exp_q.delete();
    special = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{base: 5,    num: 1, special: 1'b1, rnd: 1'b0, poke: 1'b0};
    tbl[1] = '{base: 100,  num: 3, special: 1'b0, rnd: 1'b0, poke: 1'b0};
    tbl[2] = '{base: 100,  num: 3, special: 1'b0, rnd: 1'b1, poke: 1'b1};
    tbl[3] = '{base: 1023, num: 2, special: 1'b0, rnd: 1'b0, poke: 1'b0};
    tbl[4] = '{base: 7,    num: 0, special: 1'b0, rnd: 1'b0, poke: 1'b0};

    rst = 1'b1; start = 1'b0; base = '0; num = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({rd_en, rd_addr, dram_data, valid, last, busy, done}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 5; t++) run(tbl[t]);

    // Reset in the middle of word 1, then a clean single-word transfer.
    done_cnt = 0; chunk_idx = 0;
    push_expected(200, 3);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(200); num = (AW+1)'(3);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && chunk_idx < int'(NC) + 10; i++) @(negedge clk);
    check("reached_chunk10_w1", 64'(chunk_idx >= int'(NC) + 10), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", 64'(rd_en), 64'(0));
    check("mid_rst_addr", 64'(rd_addr), 64'(0));
    check("mid_rst_data", 64'(dram_data), 64'(0));
    check("mid_rst_valid", 64'(valid), 64'(0));
    check("mid_rst_last", 64'(last), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_done_after_rst", 64'(done_cnt), 64'(0));
    check("idle_after_rst", 64'({valid, busy, rd_en}), 64'(0));
    run('{base: 40, num: 1, special: 1'b0, rnd: 1'b0, poke: 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
